// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall scheduler for the 5-stage pipeline: load-use bubbles, redirect flushes, mul/div sequencing.
// Optional perf counters (stall_cnt, flush_cnt) are built when HAZARD_PERF_CNT_EN is defined.
`ifndef REGSRC_MEM
`define REGSRC_MEM 2'b01
`endif

module pipeline_hazard_ctrl #(
    parameter int MD_LATENCY = 8,
    parameter int CNT_W      = 32
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_UseRs,
    input  logic       ID_UseRt,
    input  logic       EX_RegWrite,
    input  logic [1:0] EX_RegSrc,
    input  logic [4:0] EX_WriteReg,
    input  logic       MEM_RegWrite,
    input  logic [1:0] MEM_RegSrc,
    input  logic [4:0] MEM_WriteReg,
    input  logic       EX_Redirect,
    input  logic       EX_MulDiv,
    output logic       PC_Write,
    output logic       IFID_Write,
    output logic       IFID_Flush,
    output logic       IDEX_Write,
    output logic       IDEX_Flush,
    output logic       EXMEM_Flush,
    output logic       MD_Start,
    output logic       MD_Busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [7:0] MD_RELOAD = 8'(MD_LATENCY - 2);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic       w_lu, w_md_stall;

    // Load data is forwardable only from WB, so a load in EX or MEM feeding ID must wait.
    function automatic logic f_load_use(
        input logic       regwrite,
        input logic [1:0] regsrc,
        input logic [4:0] wreg,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       use_rs,
        input logic       use_rt
    );
        return regwrite && (regsrc == `REGSRC_MEM) && (wreg != 5'd0) &&
               ((use_rs && (rs == wreg)) || (use_rt && (rt == wreg)));
    endfunction

    assign w_lu = f_load_use(EX_RegWrite, EX_RegSrc, EX_WriteReg, ID_rs, ID_rt, ID_UseRs, ID_UseRt)
                | f_load_use(MEM_RegWrite, MEM_RegSrc, MEM_WriteReg, ID_rs, ID_rt, ID_UseRs, ID_UseRt);

    assign w_md_stall = ((r_state == IDLE) && EX_MulDiv) || ((r_state == BUSY) && (r_cnt != 8'd0));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Write  = 1'b1;
        IDEX_Flush  = 1'b0;
        EXMEM_Flush = 1'b0;
        MD_Start    = 1'b0;

        case (r_state)
            IDLE: begin
                if (EX_MulDiv) begin
                    MD_Start    = 1'b1;
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = MD_RELOAD;
                end
            end
            BUSY: begin
                if (r_cnt != 8'd0) w_cnt_nxt = r_cnt - 8'd1;
                else               w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_md_stall) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Write  = 1'b0;
            EXMEM_Flush = 1'b1;
        end else if (EX_Redirect) begin
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
        end else if (w_lu) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Flush  = 1'b1;
        end

        // Strobes must read as idle while reset is held, whatever the inputs are doing.
        if (!rstn) begin
            PC_Write    = 1'b1;
            IFID_Write  = 1'b1;
            IFID_Flush  = 1'b0;
            IDEX_Write  = 1'b1;
            IDEX_Flush  = 1'b0;
            EXMEM_Flush = 1'b0;
            MD_Start    = 1'b0;
        end
    end

    assign MD_Busy = (r_state == BUSY);

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!PC_Write && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (IFID_Flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
